register_file: RTL and testbench

- Multi-ported general-purpose register file for the multi-cycle RISC datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode and the ALU/writeback stages.
- Default configuration: 32 registers × 32 bits.

---
 rtl/register_file_pkg.sv | 9 +
 rtl/register_file_if.sv | 24 ++
 rtl/register_file_read_port.sv | 16 +
 rtl/register_file.sv | 51 +++++
 tb/tb_register_file.sv | 136 +++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and types for the register file.
package register_file_pkg;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS      = 2 ** RF_ADDR_WIDTH;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [RF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/register_file_if.sv
// Read/write port bundle. The master drives indices and write data,
// and the slave (the register file) returns the read data.
interface register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, write_enable,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, write_enable,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file_read_port.sv
// Combinational read mux. REGISTER_FILE_ZERO_REG_EN forces index 0 to read as zero.
module register_file_read_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  output logic [DATA_WIDTH-1:0] data
);
  always_comb begin
    data = regs[addr];
`ifdef REGISTER_FILE_ZERO_REG_EN
    if (addr == '0) data = '0;
`endif
  end
endmodule

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational reads, one synchronous write.
// Optional macro REGISTER_FILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_ok;

  always_comb begin
    wr_ok = bus.write_enable;
`ifdef REGISTER_FILE_ZERO_REG_EN
    if (bus.write_reg == '0) wr_ok = 1'b0;
`endif
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (wr_ok) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd1 (
    .addr (bus.read_reg1),
    .regs (regs),
    .data (bus.read_data1)
  );

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd2 (
    .addr (bus.read_reg2),
    .regs (regs),
    .data (bus.read_data2)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file with immediate-assertion checks.
`timescale 1ns/1ps
module tb_register_file;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] reg0_exp;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic read_pair(input int unsigned a, input int unsigned b);
    bus.read_reg1 = a[4:0];
    bus.read_reg2 = b[4:0];
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int unsigned i);
    logic [31:0] v;
    v = i * 32'h01010101;
    return (i == 0) ? reg0_exp : v;
  endfunction

  initial begin
`ifdef REGISTER_FILE_ZERO_REG_EN
    reg0_exp = 32'h0;
`else
    reg0_exp = 32'hDEADBEEF;
`endif
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.write_reg    = '0;
    bus.write_data   = '0;
    bus.read_reg1    = '0;
    bus.read_reg2    = '0;

    // Reset then sweep all indices.
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      read_pair(i, 31 - i);
      check($sformatf("reset_rd1[%0d]", i), bus.read_data1, 32'h0);
      check($sformatf("reset_rd2[%0d]", 31 - i), bus.read_data2, 32'h0);
    end

    // Write to register 0.
    bus.write_enable = 1'b1;
    bus.write_reg    = 5'd0;
    bus.write_data   = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus.write_enable = 1'b0;
    read_pair(0, 1);
    check("reg0_rd1", bus.read_data1, reg0_exp);
    check("reg1_rd2", bus.read_data2, 32'h0);

    // Write-enable gating.
    bus.write_reg  = 5'd5;
    bus.write_data = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    read_pair(5, 5);
    check("gate_rd1", bus.read_data1, 32'h0);
    check("gate_rd2", bus.read_data2, 32'h0);

    // Fill 1..31 and read mirrored pairs.
    for (int unsigned i = 1; i < 32; i++) begin
      bus.write_enable = 1'b1;
      bus.write_reg    = i[4:0];
      bus.write_data   = i * 32'h01010101;
      @(posedge clk);
      @(negedge clk);
    end
    bus.write_enable = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      read_pair(i, 31 - i);
      check($sformatf("sweep_rd1[%0d]", i), bus.read_data1, sweep_val(i));
      check($sformatf("sweep_rd2[%0d]", 31 - i), bus.read_data2, sweep_val(31 - i));
    end
    read_pair(31, 31);
    check("same_idx_rd1", bus.read_data1, 32'h1F1F1F1F);
    check("same_idx_rd2", bus.read_data2, 32'h1F1F1F1F);

    // Read-during-write: old value until the edge, new value after.
    bus.write_enable = 1'b1;
    bus.write_reg    = 5'd7;
    bus.write_data   = 32'hAAAA0000;
    @(posedge clk);
    @(negedge clk);
    read_pair(7, 6);
    bus.write_data = 32'h5555FFFF;
    #1;
    check("rdw_before", bus.read_data1, 32'hAAAA0000);
    @(posedge clk);
    #1;
    check("rdw_after", bus.read_data1, 32'h5555FFFF);
    check("rdw_other", bus.read_data2, 32'h06060606);
    @(negedge clk);

    // Reset with a coincident write.
    reset            = 1'b1;
    bus.write_enable = 1'b1;
    bus.write_reg    = 5'd3;
    bus.write_data   = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      read_pair(i, 31 - i);
      check($sformatf("rstpri_rd1[%0d]", i), bus.read_data1, 32'h0);
      check($sformatf("rstpri_rd2[%0d]", 31 - i), bus.read_data2, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
